// File: rtl/phist_logger.sv
// Histogram logger for p-bit output vectors: clear, acquire a window of
// qualified samples into saturating bins, then stream the bins out over valid/ready.
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | zeroing one bin per cycle
// ACQUIRE | counting accepted samples into bins
// FLUSH   | two cycles for the increment pipeline to retire
// DRAIN   | streaming bins 0..last over rd_*
// DONE    | histogram retained, waiting for a new start
module phist_logger #(
   parameter int NUM_BITS = 8,
   parameter int CNT_W    = 32,
   parameter int WIN_W    = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                abort,
   input  logic [WIN_W-1:0]    window_len,
   input  logic                sample_en,
   input  logic [NUM_BITS-1:0] sample,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [NUM_BITS-1:0] rd_index,
   output logic [CNT_W-1:0]    rd_count,
   output logic                rd_last,
   output logic                busy,
   output logic                done,
   output logic                sat_flag
);
   localparam int NBINS = 2**NUM_BITS;
   localparam logic [NUM_BITS-1:0] LAST_IDX = '1;
   localparam logic [NUM_BITS-1:0] IDX_ONE  = 1;
   localparam logic [WIN_W-1:0]    WIN_ONE  = 1;
   localparam logic [CNT_W-1:0]    CNT_ONE  = 1;

   typedef enum logic [2:0] {IDLE, CLEAR, ACQUIRE, FLUSH, DRAIN, DONE} state_t;
   state_t state, state_nx;

   logic [CNT_W-1:0]    mem [NBINS];
   logic [CNT_W-1:0]    ram_q;
   logic [NUM_BITS-1:0] raddr, waddr, drn_addr;
   logic [CNT_W-1:0]    wdata;
   logic                mem_we;

   logic [NUM_BITS-1:0] clr_idx, drn_idx, s1_idx, wb_idx;
   logic [WIN_W-1:0]    win_q, acc_cnt;
   logic                flush_cnt, s1_valid, wb_valid;
   logic [CNT_W-1:0]    wb_data, base, inc;
   logic                accept, at_max, run_start, xfer;

   assign run_start = (state == IDLE || state == DONE) && start && !abort;
   assign accept    = (state == ACQUIRE) && sample_en && (acc_cnt != win_q) && !abort;
   assign xfer      = rd_valid && rd_ready;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (start) state_nx = CLEAR;
         CLEAR:      if (clr_idx == LAST_IDX) state_nx = (win_q == '0) ? DRAIN : ACQUIRE;
         ACQUIRE:    if (accept && acc_cnt == win_q - WIN_ONE) state_nx = FLUSH;
         FLUSH:      if (!flush_cnt) state_nx = DRAIN;
         DRAIN:      if (xfer && drn_idx == LAST_IDX) state_nx = DONE;
         default:    state_nx = IDLE;
      endcase
      if (abort) state_nx = IDLE;
   end

   // Forward the previous write-back: the RAM read issued alongside it saw the stale value.
   always_comb begin
      base   = (wb_valid && wb_idx == s1_idx) ? wb_data : ram_q;
      at_max = &base;
      inc    = at_max ? base : base + CNT_ONE;
   end

   // Drain prefetch keeps ram_q equal to the bin that rd_index will show next cycle.
   always_comb begin
      drn_addr = (xfer && drn_idx != LAST_IDX) ? drn_idx + IDX_ONE : drn_idx;
      raddr    = (state == DRAIN) ? drn_addr : sample;
      mem_we   = (state == CLEAR) || s1_valid;
      waddr    = (state == CLEAR) ? clr_idx : s1_idx;
      wdata    = (state == CLEAR) ? '0 : inc;
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[waddr] <= wdata;
      ram_q <= mem[raddr];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         clr_idx   <= '0;
         flush_cnt <= 1'b1;
         win_q     <= '0;
         acc_cnt   <= '0;
         sat_flag  <= 1'b0;
         s1_valid  <= 1'b0;
         s1_idx    <= '0;
         wb_valid  <= 1'b0;
         wb_idx    <= '0;
         wb_data   <= '0;
         drn_idx   <= '0;
         rd_valid  <= 1'b0;
      end else begin
         state     <= state_nx;
         clr_idx   <= (state == CLEAR) ? clr_idx + IDX_ONE : '0;
         flush_cnt <= (state != FLUSH);
         if (run_start) begin
            win_q    <= window_len;
            acc_cnt  <= '0;
            sat_flag <= 1'b0;
         end else begin
            if (accept) acc_cnt <= acc_cnt + WIN_ONE;
            if (s1_valid && at_max) sat_flag <= 1'b1;
         end
         s1_valid <= accept;
         s1_idx   <= sample;
         wb_valid <= s1_valid;
         wb_idx   <= s1_idx;
         wb_data  <= inc;
         if (state == DRAIN && !abort) begin
            if (!rd_valid) begin
               rd_valid <= 1'b1;
            end else if (rd_ready) begin
               if (drn_idx == LAST_IDX) rd_valid <= 1'b0;
               else                     drn_idx  <= drn_idx + IDX_ONE;
            end
         end else begin
            rd_valid <= 1'b0;
            drn_idx  <= '0;
         end
      end
   end

   assign rd_index = drn_idx;
   assign rd_count = rd_valid ? ram_q : '0;
   assign rd_last  = rd_valid && (drn_idx == LAST_IDX);
   assign busy     = (state == CLEAR) || (state == ACQUIRE) || (state == FLUSH) || (state == DRAIN);
   assign done     = (state == DONE);

endmodule
